// File: rtl/router_pkt_serializer.sv
// Per-port packet serializer: valid/ready byte stream in, router serial protocol out
// (address phase, pad phase, then LSB-first data bits with frame_n/valid_n).
module router_pkt_serializer #(
    parameter int ADDR_W     = 4,
    parameter int PAD_CYCLES = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    input  logic [ADDR_W-1:0] s_dest,
    input  logic              busy_n,
    output logic              frame_n,
    output logic              valid_n,
    output logic              din,
    output logic              tx_active,
    output logic              pkt_done
);
    localparam int CNT_MAX = (ADDR_W > PAD_CYCLES) ? ADDR_W : PAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(PAD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PAD,
        S_DATA,
        S_GAP,
        S_END
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_sr, addr_nxt;
    logic [7:0]        hold_data;
    logic              hold_last, hold_full, hold_full_nxt;
    logic              last_held, last_held_nxt;
    logic [7:0]        shift, shift_nxt;
    logic              shift_last, shift_last_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic              take, accept;
    logic              frame_nxt, valid_nxt, din_nxt;

    assign s_ready = reset_n && !hold_full && !last_held
                     && ((state != S_IDLE) || busy_n) && (state != S_END);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        addr_nxt       = addr_sr;
        shift_nxt      = shift;
        shift_last_nxt = shift_last;
        bit_cnt_nxt    = bit_cnt;
        take           = 1'b0;
        last_held_nxt  = last_held || (accept && s_last);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_ADDR;
                    cnt_nxt   = '0;
                    addr_nxt  = s_dest;
                end
            end
            S_ADDR: begin
                addr_nxt = addr_sr >> 1;
                if (cnt == ADDR_LAST) begin
                    state_nxt = S_PAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_PAD: begin
                if (cnt == PAD_LAST) begin
                    state_nxt = S_DATA;
                    take      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_cnt == 3'd7) begin
                    if (shift_last)
                        state_nxt = S_END;
                    else if (hold_full)
                        take = 1'b1;
                    else
                        state_nxt = S_GAP;
                end else begin
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                end
            end
            S_GAP: begin
                if (hold_full) begin
                    state_nxt = S_DATA;
                    take      = 1'b1;
                end
            end
            S_END: begin
                state_nxt     = S_IDLE;
                last_held_nxt = 1'b0;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (take) begin
            shift_nxt      = hold_data;
            shift_last_nxt = hold_last;
            bit_cnt_nxt    = '0;
        end
        hold_full_nxt = (hold_full && !take) || accept;
    end

    // Outputs are decoded from next-cycle values so they can be registered without a lag cycle
    always_comb begin
        frame_nxt = 1'b1;
        valid_nxt = 1'b1;
        din_nxt   = 1'b0;
        case (state_nxt)
            S_ADDR: begin
                frame_nxt = 1'b0;
                din_nxt   = addr_nxt[0];
            end
            S_PAD, S_GAP: begin
                frame_nxt = 1'b0;
                din_nxt   = 1'b1;
            end
            S_DATA: begin
                frame_nxt = (bit_cnt_nxt == 3'd7) && shift_last_nxt;
                valid_nxt = 1'b0;
                din_nxt   = shift_nxt[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_sr    <= '0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            last_held  <= 1'b0;
            shift      <= '0;
            shift_last <= 1'b0;
            bit_cnt    <= '0;
            frame_n    <= 1'b1;
            valid_n    <= 1'b1;
            din        <= 1'b0;
            tx_active  <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            addr_sr    <= addr_nxt;
            hold_full  <= hold_full_nxt;
            last_held  <= last_held_nxt;
            shift      <= shift_nxt;
            shift_last <= shift_last_nxt;
            bit_cnt    <= bit_cnt_nxt;
            if (accept) begin
                hold_data <= s_data;
                hold_last <= s_last;
            end
            frame_n    <= frame_nxt;
            valid_n    <= valid_nxt;
            din        <= din_nxt;
            tx_active  <= (state_nxt != S_IDLE);
            pkt_done   <= (state_nxt == S_END);
        end
    end
endmodule

// File: tb/tb_router_pkt_serializer.sv
// Directed bench for router_pkt_serializer: cycle-exact single byte, back-to-back,
// underrun, busy gating, mid-packet reset and held-last backpressure.
module tb_router_pkt_serializer;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic [3:0] s_dest;
    logic       busy_n;
    logic       frame_n;
    logic       valid_n;
    logic       din;
    logic       tx_active;
    logic       pkt_done;

    router_pkt_serializer #(.ADDR_W(4), .PAD_CYCLES(5)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_dest    (s_dest),
        .busy_n    (busy_n),
        .frame_n   (frame_n),
        .valid_n   (valid_n),
        .din       (din),
        .tx_active (tx_active),
        .pkt_done  (pkt_done)
    );

    always #5 clock = ~clock;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Receive-side monitor state
    logic [63:0] rx_data, rx_frame;
    logic [3:0]  rx_addr;
    int unsigned rx_n, run, max_run, lead, stall, stall_hi, act_cnt, done_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        rx_data = '0; rx_frame = '0; rx_addr = '0;
        rx_n = 0; run = 0; max_run = 0; lead = 0;
        stall = 0; stall_hi = 0; act_cnt = 0; done_cnt = 0;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (tx_active) begin
                    if (act_cnt < 4) rx_addr[act_cnt] = din;
                    if (!valid_n) begin
                        rx_data  = rx_data | (64'(din) << rx_n);
                        rx_frame = rx_frame | (64'(frame_n) << rx_n);
                        rx_n++;
                        run++;
                        if (run > max_run) max_run = run;
                    end else begin
                        run = 0;
                        if (rx_n == 0) lead++;
                        else if (!frame_n) begin
                            stall++;
                            if (din) stall_hi++;
                        end
                    end
                    act_cnt++;
                end else begin
                    act_cnt = 0;
                    run     = 0;
                end
                if (pkt_done) done_cnt++;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic offer(input string tag, input logic [7:0] d, input logic l, input logic [3:0] dst);
        int unsigned k = 0;
        logic ok = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = l; s_dest = dst;
        while (!ok && k < 60) begin
            @(negedge clock);
            if (s_ready) ok = 1'b1;
            k++;
        end
        check({tag, "_accept"}, 64'(ok), 64'd1);
        @(posedge clock); #1;
    endtask

    task automatic wait_done(input string tag);
        int unsigned k = 0;
        logic seen = 1'b0;
        while (!seen && k < 80) begin
            @(negedge clock);
            if (pkt_done) seen = 1'b1;
            k++;
        end
        check({tag, "_done"}, 64'(seen), 64'd1);
        @(posedge clock); #1;
    endtask

    task automatic wait_bits(input string tag, input int unsigned n);
        int unsigned k = 0;
        while (rx_n < n && k < 60) begin
            @(negedge clock); #1;
            k++;
        end
        check({tag, "_bits_seen"}, 64'(rx_n >= n), 64'd1);
    endtask

    initial begin
        logic [63:0] cf, cv, cd, cp, ct;
        reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_dest = '0; busy_n = 1'b1;
        mon_clear();
        fork monitor(); join_none

        // Reset state
        #12;
        check("rst_frame_n", 64'(frame_n), 64'd1);
        check("rst_valid_n", 64'(valid_n), 64'd1);
        check("rst_din", 64'(din), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_tx_active", 64'(tx_active), 64'd0);
        check("rst_pkt_done", 64'(pkt_done), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1 check("idle_s_ready", 64'(s_ready), 64'd1);

        // Test 1: single byte, cycle-exact T+1..T+18
        @(posedge clock); #1;
        s_valid = 1'b1; s_data = 8'hC5; s_last = 1'b1; s_dest = 4'hA;
        #1 check("t1_ready", 64'(s_ready), 64'd1);
        @(posedge clock); #1;
        s_valid = 1'b0;
        cf = '0; cv = '0; cd = '0; cp = '0; ct = '0;
        for (int i = 0; i < 18; i++) begin
            cf = {cf[62:0], frame_n};
            cv = {cv[62:0], valid_n};
            cd = {cd[62:0], din};
            cp = {cp[62:0], pkt_done};
            ct = {ct[62:0], tx_active};
            @(posedge clock); #1;
        end
        check("t1_din", cd, 64'(18'b0101_11111_10100011_0));
        check("t1_frame_n", cf, 64'(18'b0000_00000_00000001_1));
        check("t1_valid_n", cv, 64'(18'b1111_11111_00000000_1));
        check("t1_pkt_done", cp, 64'(18'b0000_00000_00000000_1));
        check("t1_tx_active", ct, 64'(18'h3FFFF));
        check("t1_after_frame_n", 64'(frame_n), 64'd1);
        check("t1_after_ready", 64'(s_ready), 64'd1);
        check("t1_after_tx", 64'(tx_active), 64'd0);

        // Test 2: three bytes back-to-back
        mon_clear();
        offer("t2_b0", 8'h01, 1'b0, 4'h5);
        offer("t2_b1", 8'h80, 1'b0, 4'h5);
        offer("t2_b2", 8'hFF, 1'b1, 4'h5);
        s_valid = 1'b0;
        wait_done("t2");
        check("t2_nbits", 64'(rx_n), 64'd24);
        check("t2_max_run", 64'(max_run), 64'd24);
        check("t2_data", rx_data, 64'h0000_0000_00FF_8001);
        check("t2_frame_bits", rx_frame, 64'h0000_0000_0080_0000);
        check("t2_stall", 64'(stall), 64'd0);
        check("t2_addr", 64'(rx_addr), 64'h5);
        check("t2_lead", 64'(lead), 64'd9);

        // Test 3: underrun, second byte offered 3 cycles after bit 7
        mon_clear();
        offer("t3_b0", 8'h0F, 1'b0, 4'h2);
        s_valid = 1'b0;
        wait_bits("t3", 8);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
        end
        offer("t3_b1", 8'h12, 1'b1, 4'h2);
        s_valid = 1'b0;
        wait_done("t3");
        check("t3_stall", 64'(stall), 64'd4);
        check("t3_stall_din_hi", 64'(stall_hi), 64'd4);
        check("t3_nbits", 64'(rx_n), 64'd16);
        check("t3_data", rx_data, 64'h0000_0000_0000_120F);
        check("t3_addr", 64'(rx_addr), 64'h2);

        // Test 4: busy_n gating in IDLE, ignored once the packet runs
        mon_clear();
        busy_n = 1'b0;
        s_valid = 1'b1; s_data = 8'h71; s_last = 1'b1; s_dest = 4'h6;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_busy_ready", 64'(s_ready), 64'd0);
            check("t4_busy_frame_n", 64'(frame_n), 64'd1);
            check("t4_busy_tx", 64'(tx_active), 64'd0);
            @(posedge clock); #1;
        end
        busy_n = 1'b1;
        #1 check("t4_free_ready", 64'(s_ready), 64'd1);
        @(posedge clock); #1;
        s_valid = 1'b0;
        busy_n = 1'b0;
        check("t4_addr0_tx", 64'(tx_active), 64'd1);
        check("t4_addr0_frame_n", 64'(frame_n), 64'd0);
        check("t4_addr0_din", 64'(din), 64'd0);
        @(posedge clock); #1;
        check("t4_addr1_din", 64'(din), 64'd1);
        wait_done("t4");
        busy_n = 1'b1;
        check("t4_data", rx_data, 64'h71);
        check("t4_nbits", 64'(rx_n), 64'd8);
        check("t4_addr", 64'(rx_addr), 64'h6);

        // Test 5: reset during data bit 3, then a clean packet
        mon_clear();
        offer("t5_b0", 8'hF0, 1'b1, 4'h9);
        s_valid = 1'b0;
        wait_bits("t5", 4);
        check("t5_pre_valid_n", 64'(valid_n), 64'd0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_frame_n", 64'(frame_n), 64'd1);
        check("t5_rst_valid_n", 64'(valid_n), 64'd1);
        check("t5_rst_ready", 64'(s_ready), 64'd0);
        check("t5_rst_tx", 64'(tx_active), 64'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        mon_clear();
        #1 check("t5_rel_ready", 64'(s_ready), 64'd1);
        @(posedge clock); #1;
        offer("t5_b1", 8'hA6, 1'b1, 4'h3);
        s_valid = 1'b0;
        wait_done("t5");
        check("t5_data", rx_data, 64'hA6);
        check("t5_addr", 64'(rx_addr), 64'h3);
        check("t5_nbits", 64'(rx_n), 64'd8);
        check("t5_lead", 64'(lead), 64'd9);
        check("t5_done_cnt", 64'(done_cnt), 64'd1);

        // Test 6: byte offered after a held last byte waits for IDLE
        mon_clear();
        offer("t6_b0", 8'h11, 1'b0, 4'h7);
        offer("t6_b1", 8'h22, 1'b0, 4'h7);
        offer("t6_b2", 8'h33, 1'b1, 4'h7);
        offer("t6_b3", 8'h44, 1'b1, 4'hC);
        check("t6_done_before_accept", 64'(done_cnt), 64'd1);
        check("t6_p0_data", rx_data, 64'h0000_0000_0033_2211);
        check("t6_p0_nbits", 64'(rx_n), 64'd24);
        check("t6_p0_addr", 64'(rx_addr), 64'h7);
        mon_clear();
        s_valid = 1'b0;
        wait_done("t6");
        check("t6_p1_data", rx_data, 64'h44);
        check("t6_p1_addr", 64'(rx_addr), 64'hC);
        check("t6_p1_nbits", 64'(rx_n), 64'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
